mux_sequencer: RTL

MUX_SEQUENCER -- requirements
Module: mux_sequencer

---
 rtl/mux_pkg.sv | 14 +
 rtl/frame_scanner.sv | 62 ++++++
 rtl/mux_sequencer.sv | 119 +++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the mux sequencer: write-side FSM states and default geometry.
package mux_pkg;

  typedef enum logic [1:0] {
    ACCEPT,
    COMMIT,
    WAIT_SWAP
  } write_state_e;

  localparam int DEFAULT_WIDTH     = 16;
  localparam int DEFAULT_NUM_REG   = 3;
  localparam int DEFAULT_FRAME_LEN = 8;

endpackage

// File: rtl/frame_scanner.sv
// Read side of the sequencer: walks a fixed frame, latches the register file at frame start
// and streams each register out one cycle after its read address was presented.
module frame_scanner
  import mux_pkg::*;
#(
  parameter  int width      = DEFAULT_WIDTH,
  parameter  int num_reg    = DEFAULT_NUM_REG,
  parameter  int frame_len  = DEFAULT_FRAME_LEN,
  localparam int addr_width = $clog2(num_reg)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic [width-1:0]      read_data,
  output logic [addr_width-1:0] read_addr,
  output logic                  read_latch,
  output logic                  out_valid,
  output logic [addr_width-1:0] out_addr,
  output logic [width-1:0]      out_data
);

  localparam int fc_width = $clog2(frame_len);

  logic [fc_width-1:0] fc;
  logic                active;

  // A frame in progress always runs to its end; only a new frame start waits on run.
  assign active = (fc != '0) || run;

  always_ff @(posedge clk) begin
    if (rst) begin
      fc <= '0;
    end else if (active) begin
      if (fc == fc_width'(frame_len - 1)) begin
        fc <= '0;
      end else begin
        fc <= fc + fc_width'(1);
      end
    end
  end

  always_comb begin
    read_latch = 1'b0;
    read_addr  = '0;
    out_valid  = 1'b0;
    out_addr   = '0;
    out_data   = '0;
    if (!rst) begin
      read_latch = (fc == '0) && run;
      if (fc >= fc_width'(1) && fc <= fc_width'(num_reg)) begin
        read_addr = addr_width'(fc - fc_width'(1));
      end
      // Read data trails its address by one cycle, so the output window is shifted by one.
      if (fc >= fc_width'(2) && fc <= fc_width'(num_reg + 1)) begin
        out_valid = 1'b1;
        out_addr  = addr_width'(fc - fc_width'(2));
        out_data  = read_data;
      end
    end
  end

endmodule

// File: rtl/mux_sequencer.sv
// Accepts host register updates into the shadow side of a double-buffered register file,
// commits them between frame latches, and scans the live side out frame by frame.
module mux_sequencer
  import mux_pkg::*;
#(
  parameter  int width      = DEFAULT_WIDTH,
  parameter  int num_reg    = DEFAULT_NUM_REG,
  parameter  int frame_len  = DEFAULT_FRAME_LEN,
  localparam int addr_width = $clog2(num_reg)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [addr_width-1:0] in_addr,
  input  logic [width-1:0]      in_data,
  input  logic                  in_last,
  input  logic                  run,
  output logic [addr_width-1:0] write_addr,
  output logic [width-1:0]      write_data,
  output logic                  write_enable,
  output logic                  write_done,
  output logic [addr_width-1:0] read_addr,
  output logic                  read_latch,
  input  logic [width-1:0]      read_data,
  output logic                  out_valid,
  output logic [addr_width-1:0] out_addr,
  output logic [width-1:0]      out_data,
  output logic                  commit_pending,
  output logic                  addr_err
);

  if (frame_len < num_reg + 2) begin : g_bad_frame_len
    $error("mux_sequencer: frame_len must be at least num_reg+2");
  end
  if (num_reg < 2) begin : g_bad_num_reg
    $error("mux_sequencer: num_reg must be at least 2");
  end

  write_state_e state, state_next;
  logic         accept;
  logic         addr_ok;

  assign accept  = in_valid && in_ready;
  assign addr_ok = int'(in_addr) < num_reg;

  frame_scanner #(
    .width     (width),
    .num_reg   (num_reg),
    .frame_len (frame_len)
  ) u_scanner (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .read_data  (read_data),
    .read_addr  (read_addr),
    .read_latch (read_latch),
    .out_valid  (out_valid),
    .out_addr   (out_addr),
    .out_data   (out_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ACCEPT;
      write_enable <= 1'b0;
      write_addr   <= '0;
      write_data   <= '0;
      addr_err     <= 1'b0;
    end else begin
      state        <= state_next;
      write_enable <= 1'b0;
      if (accept && addr_ok) begin
        write_enable <= 1'b1;
        write_addr   <= in_addr;
        write_data   <= in_data;
      end
      if (accept && !addr_ok) begin
        addr_err <= 1'b1;
      end
    end
  end

  // write_done must never share a cycle with read_latch, or the swap could see a half-marked commit.
  always_comb begin
    state_next     = state;
    in_ready       = 1'b0;
    write_done     = 1'b0;
    commit_pending = 1'b0;
    case (state)
      ACCEPT: begin
        in_ready = 1'b1;
        if (in_valid && in_last) begin
          state_next = COMMIT;
        end
      end
      COMMIT: begin
        if (!read_latch) begin
          write_done     = 1'b1;
          commit_pending = 1'b1;
          state_next     = WAIT_SWAP;
        end
      end
      WAIT_SWAP: begin
        commit_pending = 1'b1;
        if (read_latch) begin
          state_next = ACCEPT;
        end
      end
      default: state_next = ACCEPT;
    endcase
    if (rst) begin
      in_ready       = 1'b0;
      write_done     = 1'b0;
      commit_pending = 1'b0;
    end
  end

endmodule
